// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM stream reader and its output buffer.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/rom_stream_buf.sv
// Two-entry FIFO holding ROM read data until the stream consumer accepts it.
module rom_stream_buf
  import rom_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  // Storage, pointers and occupancy; push and pop in one cycle keep the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= {DATA_WIDTH{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

  rom_stream_buf_chk u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_push),
    .i_pop   (i_pop),
    .i_count (r_count)
  );

endmodule

// File: rtl/rom_stream_buf_chk.sv
// Protocol checker for the 2-entry stream buffer: a push into a full buffer
// without a simultaneous pop would overwrite an undelivered word.
module rom_stream_buf_chk (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [1:0] i_count
);

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && (i_count == 2'd2)));

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a run of words from a 1-cycle-latency synchronous ROM and streams them
// out on valid/ready, keeping at most two words buffered or in flight.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  parameter  int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [LEN_WIDTH-1:0]  r_issue_rem;
  logic [LEN_WIDTH-1:0]  r_beat_rem;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_occ;
  logic                  w_pop;
  logic [2:0]            w_credit;
  logic [2:0]            w_limit;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // r_addr_cnt doubles as the ROM address, so an issue reads r_addr_cnt that cycle.
  assign w_pop       = o_m_valid && i_m_ready;
  assign w_credit    = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_limit     = 3'd2 + {2'b00, w_pop};
  assign w_issue     = (r_state == S_RUN) && (r_issue_rem != {LEN_WIDTH{1'b0}}) &&
                       (w_credit < w_limit);
  assign w_addr_next = (r_addr_cnt == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                               : r_addr_cnt + ADDR_WIDTH'(1);

  // Command FSM, address/length counters and the read-in-flight flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr_cnt  <= {ADDR_WIDTH{1'b0}};
      r_issue_rem <= {LEN_WIDTH{1'b0}};
      r_beat_rem  <= {LEN_WIDTH{1'b0}};
      r_inflight  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_length != {LEN_WIDTH{1'b0}}) begin
              r_state     <= S_RUN;
              r_addr_cnt  <= i_start_addr;
              r_issue_rem <= i_length;
              r_beat_rem  <= i_length;
              r_busy      <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr_cnt  <= w_addr_next;
            r_issue_rem <= r_issue_rem - LEN_WIDTH'(1);
            if (r_issue_rem == LEN_WIDTH'(1)) r_state <= S_DRAIN;
          end
          if (w_pop) r_beat_rem <= r_beat_rem - LEN_WIDTH'(1);
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_beat_rem <= r_beat_rem - LEN_WIDTH'(1);
            if (r_beat_rem == LEN_WIDTH'(1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  rom_stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_inflight),
    .i_push_data (i_rd_data),
    .i_pop       (w_pop),
    .o_head_data (o_m_data),
    .o_count     (w_occ)
  );

  assign o_m_valid = (w_occ != 2'd0);
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rd_addr = r_addr_cnt;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a synchronous ROM holding addr+0x10.
module tb_rom_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] start_addr = 3'd0;
  logic [3:0] length = 4'd0;
  logic       busy, done, m_valid;
  logic [2:0] rd_addr;
  logic [7:0] rd_data, m_data;
  logic       m_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rd_data <= 8'h10 + {5'd0, rd_addr};

  rom_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_length     (length),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a run with m_ready high; cycle c counts from the start cycle (c=0).
  task automatic run_full(input int addr, input int len, input bit mid);
    start = 1'b1; start_addr = 3'(addr); length = 4'(len); m_ready = 1'b1;
    for (int c = 1; c <= len + 3; c++) begin
      step();
      start = 1'b0;
      if (mid && c == 2) begin
        start = 1'b1; start_addr = 3'd4; length = 4'd2;
      end
      if (c <= len) chk("rd_addr", 32'(rd_addr), 32'((addr + c - 1) % DEPTH));
      if (c >= 3 && c <= len + 2) begin
        chk("m_valid", 32'(m_valid), 32'd1);
        chk("m_data", 32'(m_data), 32'(8'h10 + (addr + c - 3) % DEPTH));
      end else begin
        chk("m_valid_idle", 32'(m_valid), 32'd0);
      end
      chk("done", 32'(done), 32'(c == len + 3));
      chk("busy", 32'(busy), 32'(c != len + 3));
    end
    step();
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] pat;
    int          exp_idx, issued, accepted, done_cnt;
    logic [2:0]  prev_addr, rd_before;
    logic [7:0]  held;
    bit          holding;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic stream 2..5: data 0x12..0x15 in cycles 3..6, done in cycle 7
    run_full(2, 4, 1'b0);
    // Wrap: addresses 6,7,0,1 -> 0x16,0x17,0x10,0x11
    run_full(6, 4, 1'b0);
    // Full sweep
    run_full(0, 8, 1'b0);
    // Start mid-transfer is ignored
    run_full(0, 6, 1'b1);

    // Zero length: done next cycle, no address movement, never busy
    rd_before = rd_addr;
    start = 1'b1; start_addr = 3'd5; length = 4'd0;
    step();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_addr", 32'(rd_addr), 32'(rd_before));
    step();
    chk("len0_done_clr", 32'(done), 32'd0);
    chk("len0_addr2", 32'(rd_addr), 32'(rd_before));
    chk("len0_valid", 32'(m_valid), 32'd0);

    // Backpressure: length 5 from address 1, ready pattern LSB first 1,0,0,1,0,1,...
    pat = 16'b1011_0010_1010_1001;
    exp_idx = 0; issued = 0; accepted = 0; done_cnt = 0; holding = 1'b0; held = 8'h00;
    start = 1'b1; start_addr = 3'd1; length = 4'd5; m_ready = pat[0];
    step();
    start = 1'b0;
    prev_addr = rd_addr;
    for (int c = 1; c < 60 && done_cnt == 0; c++) begin
      m_ready = pat[c % 16];
      if (rd_addr != prev_addr) issued++;
      prev_addr = rd_addr;
      chk("bp_outstanding", 32'(issued - accepted <= 2), 32'd1);
      if (holding) begin
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        chk("bp_hold_data", 32'(m_data), 32'(held));
      end
      holding = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) begin
        chk("bp_data", 32'(m_data), 32'(8'h11 + exp_idx));
        exp_idx++;
        accepted++;
      end
      if (done) done_cnt++;
      step();
      if (done) done_cnt++;
    end
    chk("bp_count", 32'(exp_idx), 32'd5);
    chk("bp_done_once", 32'(done_cnt), 32'd1);
    chk("bp_final_addr", 32'(rd_addr), 32'd6);
    chk("bp_busy_end", 32'(busy), 32'd0);
    step();
    chk("bp_done_clr", 32'(done), 32'd0);

    // Reset with two words buffered
    start = 1'b1; start_addr = 3'd3; length = 4'd6; m_ready = 1'b0;
    step(); start = 1'b0;
    step(); step(); step();
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_data", 32'(m_data), 32'h13);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    step();
    rst = 1'b0;
    step();
    run_full(5, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Address sequencer and output buffer that sits directly upstream of the synchronous ROM: drives its read address and consumes its registered read data.
- On a start command, reads LENGTH words beginning at a base address, wrapping at DEPTH.
- Presents each word on a valid/ready stream with full backpressure support.
- Hides the ROM's fixed 1-cycle read latency with a 2-entry buffer, sustaining 1 word/cycle while m_ready stays high.

Parameters:
DATA_WIDTH, 8, ROM word width
DEPTH, 8, ROM depth in words
ADDR_WIDTH, $clog2(DEPTH), localparam, ROM address width
LEN_WIDTH, ADDR_WIDTH+1, width of the length field; allows reading a full DEPTH sweep

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
start_addr  in  ADDR_WIDTH  first ROM address to read
length  in  LEN_WIDTH  number of words to read
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last word handshakes on m_*
rd_addr  out  ADDR_WIDTH  to ROM address input; registered
rd_data  in  DATA_WIDTH  from ROM; valid the cycle after rd_addr is issued
m_data  out  DATA_WIDTH  stream data, buffer head
m_valid  out  1  stream valid
m_ready  in  1  stream ready from consumer

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy=0, done=0, m_valid=0, rd_addr=0, m_data=0; in-flight flag, buffer and counters cleared. Applies at any time, including mid-transfer: words in flight or buffered are discarded.
- State machine (enum in package): IDLE, RUN, DRAIN.
- IDLE
  - start=1 and length!=0: latch addr_cnt=start_addr, issue_rem=length, beat_rem=length; go to RUN; busy=1 next cycle.
  - start=1 and length=0: stay in IDLE; done pulses the next cycle; busy stays 0.
- RUN (issue rule)
  - Issue condition: issue_rem!=0 and (occupancy + inflight − pop) < 2, where pop = m_valid && m_ready.
  - On issue: rd_addr presents addr_cnt that cycle; next cycle inflight=1 and the ROM returns data.
  - addr_cnt increments; at DEPTH-1 it wraps to 0 (explicit compare; DEPTH need not be a power of 2).
  - issue_rem decrements. When it reaches 0, go to DRAIN.
- DRAIN: no further issues. When beat_rem reaches 0: done=1 for one cycle, busy=0, return to IDLE.
- Data capture: when inflight=1, rd_data is pushed into the 2-entry buffer at the end of that cycle. Push and pop in the same cycle leave occupancy unchanged.
- Overflow: the credit rule guarantees the buffer never overflows. A push to a full buffer is a design error and is flagged by an assertion.
- Stream rules:
  - m_valid = occupancy!=0.
  - m_data is stable while m_valid && !m_ready.
  - beat_rem decrements on each handshake.
- Latency, m_ready held high: start in cycle 0 → rd_addr=start_addr in cycle 1 → m_valid=1 with word 0 in cycle 2+1=3. Thereafter one word per cycle; done on the cycle after the last handshake.
- m_ready low: issuing stalls once 2 words are buffered or in flight. No word is dropped or duplicated.
- start while busy: ignored.

Decomposition:
- Package rom_stream_pkg: state_t enum {IDLE, RUN, DRAIN}; BUF_DEPTH=2 constant.
- Sub-module rom_stream_buf: 2-entry FIFO. Ports: push/push_data, pop, head data, occupancy. Synchronous write, async-reset pointers.
- Top level holds the FSM, address/length counters, inflight flag and credit logic, and instantiates the ROM-facing interface only; the ROM itself is instantiated by the parent alongside this block.

Test Plan:
- Basic stream: ROM preloaded with value = addr+0x10; start_addr=2, length=4, m_ready=1 → m_data 0x12,0x13,0x14,0x15 on consecutive cycles; first m_valid in cycle 3; done one pulse after 0x15.
- Wrap: DEPTH=8, start_addr=6, length=4 → rd_addr sequence 6,7,0,1; data 0x16,0x17,0x10,0x11.
- Backpressure: length=5, m_ready toggled 1,0,0,1,0,1,...
  - every word appears exactly once, in order;
  - m_data holds while m_valid && !m_ready;
  - no more than 2 reads issued ahead of accepted beats.
- Edge commands:
  - length=0 → done pulse the next cycle, no rd_addr activity, busy stays 0;
  - length=8 from addr 0 → all 8 words delivered;
  - start asserted mid-transfer → ignored.
- Reset mid-operation: assert rst asynchronously while 2 words are buffered → m_valid, busy, done drop to 0 immediately. A new start after reset streams correctly from the new start_addr.
